// File: rtl/div_result_buffer.sv
// div_result_buffer
// -----------------
// Result buffer and issue-credit controller placed after the 6-stage 8-by-3
// pipelined divider. The divider cannot be stalled, so this block only grants
// an issue when a FIFO slot is guaranteed for the resulting quotient. Results
// are stored in order and handed to the consumer with a valid/ready handshake.
//
// Ports
//   clk              in   single clock, rising edge
//   reset            in   synchronous, active-high
//   issue_valid      in   upstream wants to launch one division
//   issue_ready      out  credit available (combinational from registers)
//   res_valid_in     in   divider valid_out
//   res_quotient_in  in   divider quotient
//   out_valid        out  FIFO non-empty (registered)
//   out_ready        in   consumer accepts head entry
//   out_quotient     out  head entry, 0 when out_valid = 0
//   occupancy        out  entries stored
//   inflight         out  issued results not yet returned
//   err_overflow     out  sticky: result arrived into a full, non-popping FIFO
//   err_spurious     out  sticky: result arrived with nothing in flight

module div_result_buffer #(
    parameter int QWIDTH = 6,
    parameter int DEPTH  = 8,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              res_valid_in,
    input  logic [QWIDTH-1:0] res_quotient_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [QWIDTH-1:0] out_quotient,
    output logic [CW-1:0]     occupancy,
    output logic [CW-1:0]     inflight,
    output logic              err_overflow,
    output logic              err_spurious
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

    logic [QWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     occ_q;
    logic [CW-1:0]     infl_q;
    logic              out_valid_q;
    logic              err_ovf_q;
    logic              err_spur_q;

    logic              full;
    logic              issue;
    logic              pop;
    logic              push;
    logic              ret;
    logic [CW-1:0]     occ_n;
    logic [CW-1:0]     infl_n;

    assign full  = ({1'b0, occ_q} == DEPTH_X);

    // Credit is computed only from registered counts, so a pop this cycle
    // frees a slot for issue next cycle and issue_valid never loops back.
    assign issue_ready = (({1'b0, occ_q} + {1'b0, infl_q}) < DEPTH_X);

    assign issue = issue_valid && issue_ready;
    assign pop   = out_valid_q && out_ready;
    assign push  = res_valid_in && (!full || pop);
    // A result with nothing outstanding must not underflow the counter.
    assign ret   = res_valid_in && (infl_q != '0);

    always_comb begin
        occ_n  = occ_q;
        infl_n = infl_q;
        if (push && !pop) occ_n = occ_q + 1'b1;
        if (pop && !push) occ_n = occ_q - 1'b1;
        if (issue && !ret) infl_n = infl_q + 1'b1;
        if (ret && !issue) infl_n = infl_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ_q       <= '0;
            infl_q      <= '0;
            out_valid_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_spur_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occ_q       <= occ_n;
            infl_q      <= infl_n;
            out_valid_q <= (occ_n != '0);
            if (res_valid_in && full && !pop) err_ovf_q <= 1'b1;
            if (res_valid_in && (infl_q == '0)) err_spur_q <= 1'b1;
        end
    end

    // Storage needs no reset: every entry is written before out_valid can
    // expose it, and out_quotient is masked while empty.
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= res_quotient_in;
    end

    assign out_valid    = out_valid_q;
    assign out_quotient = out_valid_q ? mem[rd_ptr] : '0;
    assign occupancy    = occ_q;
    assign inflight     = infl_q;
    assign err_overflow = err_ovf_q;
    assign err_spurious = err_spur_q;

endmodule

// File: tb/tb_div_result_buffer.sv
// Testbench for div_result_buffer. A behavioural 6-stage divider model feeds
// the buffer; violation scenarios override its output directly.

module tb_div_result_buffer;

    localparam int QW = 6;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic          res_valid_in;
    logic [QW-1:0] res_quotient_in;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [QW-1:0] out_quotient;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] inflight;
    logic          err_overflow;
    logic          err_spurious;

    logic [7:0]    op_a = 8'd0;
    logic [2:0]    op_b = 3'd1;
    logic          force_v = 1'b0;
    logic [QW-1:0] force_q = '0;

    logic [5:0]    pv = 6'd0;
    logic [QW-1:0] pq [6] = '{default: '0};

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Divider model: six register stages, quotient truncated to QW bits.
    always @(posedge clk) begin
        pv    <= {pv[4:0], issue_valid && issue_ready};
        pq[0] <= QW'(op_a / op_b);
        for (int i = 1; i < 6; i++) pq[i] <= pq[i-1];
    end

    assign res_valid_in    = pv[5] | force_v;
    assign res_quotient_in = force_v ? force_q : pq[5];

    div_result_buffer #(.QWIDTH(QW), .DEPTH(D), .CW(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .res_valid_in    (res_valid_in),
        .res_quotient_in (res_quotient_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_quotient    (out_quotient),
        .occupancy       (occupancy),
        .inflight        (inflight),
        .err_overflow    (err_overflow),
        .err_spurious    (err_spurious)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b want 1", issue_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (occupancy !== 4'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy); else passed++;
        total++; if (inflight !== 4'd0) $display("FAIL reset_inflight: got %0d want 0", inflight); else passed++;
        total++; if (err_overflow !== 1'b0) $display("FAIL reset_err_overflow: got %b want 0", err_overflow); else passed++;
        total++; if (err_spurious !== 1'b0) $display("FAIL reset_err_spurious: got %b want 0", err_spurious); else passed++;
        total++; if (out_quotient !== 6'd0) $display("FAIL reset_out_quotient: got %0d want 0", out_quotient); else passed++;
    endtask

    task automatic test_single();
        op_a = 8'd200;
        op_b = 3'd7;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            total++; if (inflight !== 4'd1) $display("FAIL single_inflight_c%0d: got %0d want 1", c, inflight); else passed++;
            total++; if (out_valid !== 1'b0) $display("FAIL single_early_valid_c%0d: got %b want 0", c, out_valid); else passed++;
            if (c < 6) tick();
        end
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_quotient !== 6'd28) $display("FAIL single_quotient: got %0d want 28", out_quotient); else passed++;
        total++; if (inflight !== 4'd0) $display("FAIL single_inflight_done: got %0d want 0", inflight); else passed++;
        total++; if (occupancy !== 4'd1) $display("FAIL single_occupancy: got %0d want 1", occupancy); else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (occupancy !== 4'd0) $display("FAIL single_pop_occupancy: got %0d want 0", occupancy); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL single_pop_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_credit();
        int accepted;
        accepted = 0;
        out_ready = 1'b0;
        op_b = 3'd1;
        issue_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            op_a = 8'(accepted);
            if (issue_ready) accepted++;
            tick();
        end
        issue_valid = 1'b0;
        total++; if (accepted !== 8) $display("FAIL credit_accepted: got %0d want 8", accepted); else passed++;
        total++; if (issue_ready !== 1'b0) $display("FAIL credit_issue_ready: got %b want 0", issue_ready); else passed++;
        total++; if (occupancy !== 4'd8) $display("FAIL credit_occupancy: got %0d want 8", occupancy); else passed++;
        total++; if (inflight !== 4'd0) $display("FAIL credit_inflight: got %0d want 0", inflight); else passed++;
        total++; if (err_overflow !== 1'b0) $display("FAIL credit_err_overflow: got %b want 0", err_overflow); else passed++;
        total++; if (err_spurious !== 1'b0) $display("FAIL credit_err_spurious: got %b want 0", err_spurious); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (out_valid !== 1'b1 || out_quotient !== 6'(i))
                $display("FAIL credit_drain_%0d: got valid=%b q=%0d want valid=1 q=%0d", i, out_valid, out_quotient, i);
            else passed++;
            tick();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL credit_drained: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_full_pop();
        int expq;
        out_ready = 1'b0;
        op_b = 3'd1;
        for (int i = 0; i < 8; i++) begin
            op_a = 8'(i);
            issue_valid = 1'b1;
            tick();
        end
        issue_valid = 1'b0;
        repeat (5) tick();
        total++; if (occupancy !== 4'd7) $display("FAIL fullpop_occ_before: got %0d want 7", occupancy); else passed++;
        out_ready = 1'b1;
        expq = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                total++; if (out_quotient !== 6'(expq))
                    $display("FAIL fullpop_order_%0d: got %0d want %0d", expq, out_quotient, expq);
                else passed++;
                expq++;
            end
            tick();
            if (c == 0) begin
                total++; if (occupancy !== 4'd7) $display("FAIL fullpop_push_pop_occ: got %0d want 7", occupancy); else passed++;
            end
            total++; if (occupancy > 4'd8) $display("FAIL fullpop_occ_bound: got %0d want <=8", occupancy); else passed++;
        end
        out_ready = 1'b0;
        total++; if (expq !== 8) $display("FAIL fullpop_count: got %0d want 8", expq); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL fullpop_empty: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        out_ready = 1'b1;
        op_b = 3'd3;
        for (int c = 0; c < 112; c++) begin
            issue_valid = (c < 100);
            op_a = 8'(c);
            if (c < 100) begin
                total++; if (issue_ready !== 1'b1) $display("FAIL b2b_issue_ready_%0d: got %b want 1", c, issue_ready); else passed++;
            end
            tick();
            exp_v = (c >= 6 && c < 106);
            total++; if (out_valid !== exp_v) $display("FAIL b2b_valid_%0d: got %b want %b", c, out_valid, exp_v); else passed++;
            if (exp_v) begin
                total++; if (out_quotient !== 6'((c - 6) / 3))
                    $display("FAIL b2b_quotient_%0d: got %0d want %0d", c - 6, out_quotient, (c - 6) / 3);
                else passed++;
            end
        end
        issue_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_violations();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        force_v = 1'b1;
        force_q = 6'd5;
        tick();
        force_v = 1'b0;
        total++; if (err_spurious !== 1'b1) $display("FAIL viol_spurious: got %b want 1", err_spurious); else passed++;
        total++; if (occupancy !== 4'd1) $display("FAIL viol_spurious_pushed: got %0d want 1", occupancy); else passed++;
        total++; if (inflight !== 4'd0) $display("FAIL viol_spurious_inflight: got %0d want 0", inflight); else passed++;
        total++; if (err_overflow !== 1'b0) $display("FAIL viol_spurious_ovf: got %b want 0", err_overflow); else passed++;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (err_spurious !== 1'b0) $display("FAIL viol_reset_spurious: got %b want 0", err_spurious); else passed++;
        total++; if (occupancy !== 4'd0) $display("FAIL viol_reset_occ: got %0d want 0", occupancy); else passed++;

        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            force_v = 1'b1;
            force_q = 6'(10 + i);
            tick();
            if (i == 7) begin
                total++; if (occupancy !== 4'd8) $display("FAIL viol_occ_at_8: got %0d want 8", occupancy); else passed++;
                total++; if (err_overflow !== 1'b0) $display("FAIL viol_ovf_early: got %b want 0", err_overflow); else passed++;
            end
        end
        force_v = 1'b0;
        total++; if (err_overflow !== 1'b1) $display("FAIL viol_overflow: got %b want 1", err_overflow); else passed++;
        total++; if (occupancy !== 4'd8) $display("FAIL viol_overflow_occ: got %0d want 8", occupancy); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (out_valid !== 1'b1 || out_quotient !== 6'(10 + i))
                $display("FAIL viol_drain_%0d: got valid=%b q=%0d want valid=1 q=%0d", i, out_valid, out_quotient, 10 + i);
            else passed++;
            tick();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL viol_ninth_dropped: got %b want 0", out_valid); else passed++;

        op_b = 3'd1;
        for (int i = 0; i < 2; i++) begin
            op_a = 8'(40 + i);
            issue_valid = 1'b1;
            tick();
        end
        issue_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (inflight !== 4'd0) $display("FAIL midreset_inflight: got %0d want 0", inflight); else passed++;
        total++; if (err_overflow !== 1'b0 || err_spurious !== 1'b0)
            $display("FAIL midreset_errs: got ovf=%b spur=%b want 0 0", err_overflow, err_spurious);
        else passed++;
        total++; if (issue_ready !== 1'b1) $display("FAIL midreset_issue_ready: got %b want 1", issue_ready); else passed++;
        total++; if (out_quotient !== 6'd0) $display("FAIL midreset_quotient: got %0d want 0", out_quotient); else passed++;
        repeat (8) tick();
        total++; if (err_spurious !== 1'b1) $display("FAIL midreset_late_spurious: got %b want 1", err_spurious); else passed++;
        total++; if (occupancy !== 4'd2) $display("FAIL midreset_late_occ: got %0d want 2", occupancy); else passed++;
        total++; if (out_quotient !== 6'd40) $display("FAIL midreset_late_head: got %0d want 40", out_quotient); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit();
        test_full_pop();
        test_back_to_back();
        test_violations();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div_result_buffer.md
# div_result_buffer

Result buffer and credit controller placed directly downstream of the 6-stage 8-by-3 pipelined divider (Div_8_3_STAGE6).

- The divider has no backpressure, so this block grants issue credits upstream. An operand pair may enter the divider only when a buffer slot is guaranteed for its result.
- It stores quotients in order in a FIFO and presents them to the consumer through a valid/ready handshake.
- It flags protocol violations, such as a result arriving with no credit outstanding or arriving into a full FIFO.

## Interface
- QWIDTH, 6, quotient width; matches the divider output.
- DEPTH, 8, FIFO entries; power of two, ≥ 2.
- CW, $clog2(DEPTH+1), width of the occupancy and in-flight counters.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- issue_valid  in  1  upstream requests to launch one division this cycle.
- issue_ready  out  1  credit available; an issue is accepted when issue_valid && issue_ready.
- res_valid_in  in  1  divider valid_out.
- res_quotient_in  in  QWIDTH  divider quotient.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_quotient  out  QWIDTH  head entry; 0 when out_valid = 0.
- occupancy  out  CW  entries currently stored.
- inflight  out  CW  issued results not yet returned.
- err_overflow  out  1  sticky: a result arrived while the FIFO was full and not popping.
- err_spurious  out  1  sticky: res_valid_in arrived with inflight = 0.

## Operation
- State:
  - memory mem[DEPTH];
  - wr_ptr and rd_ptr, log2(DEPTH) bits each, wrapping modulo DEPTH;
  - occupancy and inflight registers;
  - two sticky error flags.
- Event definitions:
  - issue = issue_valid && issue_ready
  - pop = out_valid && out_ready
  - push = res_valid_in && (occupancy < DEPTH || pop)
- issue_ready = (occupancy + inflight) < DEPTH, computed combinationally from registered values only.
  - A same-cycle pop does not add credit until the next cycle.
  - issue_valid never feeds issue_ready (no combinational loop).
- inflight next value:
  - inflight + issue − (res_valid_in && inflight ≠ 0)
  - issue and a result in the same cycle leave it unchanged.
- occupancy next value: occupancy + push − pop.
- Push: write mem[wr_ptr] ← res_quotient_in, then wr_ptr++.
- Pop: rd_ptr++.
- Full with simultaneous pop: the write is accepted; occupancy stays DEPTH.
- Empty: out_valid = 0 and pop cannot occur.
  - A push into an empty FIFO is visible on out_valid in the next cycle; there is no same-cycle bypass.
- Error flags:
  - res_valid_in while occupancy = DEPTH and no pop: the result is dropped and err_overflow is set.
  - res_valid_in with inflight = 0: err_spurious is set; the result is still pushed if space allows.
  - Both flags clear only on reset.
- Credit invariant: with a compliant upstream, occupancy + inflight ≤ DEPTH always holds, so err_overflow can never set.

## Timing
- Reset (any cycle, including mid-operation):
  - ptrs, occupancy, inflight = 0;
  - err flags = 0; out_valid = 0; out_quotient = 0; issue_ready = 1 from the first cycle after reset;
  - results of divisions in flight at reset are later flagged err_spurious if they arrive.
- Result latency: res_valid_in at edge N gives out_valid = 1 with that quotient after edge N+1 (1 cycle).
- Issue-to-output latency with the divider: 7 cycles (6 divider + 1 buffer).
- Throughput: one issue, one push and one pop per cycle, sustained.
- out_quotient and out_valid remain stable while out_valid && !out_ready.
- All outputs except issue_ready and out_quotient are registered.
  - issue_ready and out_quotient are combinational functions of registers only.

## Test plan
- Reset then idle.
  - Stimulus: reset held 2 cycles, then released.
  - Required: issue_ready = 1, out_valid = 0, occupancy = 0, inflight = 0, both err flags = 0.
- Single operation with the divider.
  - Stimulus: issue 200/7 at cycle 0.
  - Required: inflight = 1 for cycles 1–6; out_valid rises after cycle 7 with out_quotient = 28; a pop then returns occupancy to 0.
- Credit exhaustion.
  - Stimulus: out_ready = 0; issue every cycle.
  - Required: exactly 8 issues accepted, then issue_ready = 0; occupancy reaches 8; inflight reaches 0; err_overflow stays 0.
- Full with simultaneous push/pop.
  - Stimulus: 8 issues; at the 8th result arrival occupancy = 7; out_ready held high.
  - Required: occupancy stays ≤ 8, FIFO order is preserved, and quotients 0..7 drain in order.
- Back-to-back streaming.
  - Stimulus: out_ready = 1; issue 100 consecutive divisions x/3 with x = 0..99.
  - Required: issue_ready never drops; outputs x/3 appear in order on consecutive cycles starting 7 cycles after the first issue.
- Violations.
  - Stimulus: force res_valid_in with inflight = 0.
  - Required: err_spurious = 1.
  - Stimulus: force 9 results with out_ready = 0.
  - Required: err_overflow = 1, occupancy = 8, the 9th value is dropped; a reset mid-stream clears all state.
